if_id_fetch_stage: RTL and testbench
====================================

Name: if_id_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage pipeline.
- Owns the PC and drives a single-outstanding request/grant instruction-memory port.
- Presents fetched instructions to decode with a valid bit.
- Honours the hazard unit's PC-write and IF/ID-write enables, and the branch/jump redirect from EX.
- Buffers one instruction that returns from memory while the pipe is stalled.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  system clock, all state changes on rising edge
- rst  input  1  synchronous active-low reset (0 = reset, sampled on rising clk)
- pc_en  input  1  PC write enable from hazard unit (0 = stall PC)
- ifid_en  input  1  IF/ID write enable from hazard unit (0 = hold IF/ID)
- redirect  input  1  branch taken / jump from EX; flush and reload PC
- redirect_pc  input  32  target address for redirect
- imem_req  output  1  fetch request valid
- imem_addr  output  32  fetch address, word aligned
- imem_gnt  input  1  memory accepted request; imem_rdata valid this same cycle
- imem_rdata  input  32  instruction word
- ifid_valid  output  1  IF/ID holds a real instruction
- ifid_pc  output  32  PC of instruction in IF/ID
- ifid_pc4  output  32  ifid_pc + 4
- ifid_instr  output  32  instruction in IF/ID
- pc  output  32  current fetch PC
- stall_cnt  output  CNT_W  cycles with ifid_en=0 while ifid_valid=1, saturating

Behaviour:
- Reset (rst=0 at edge):
  - pc=RESET_PC; ifid_valid=0; ifid_pc, ifid_pc4, ifid_instr=0; stall_cnt=0.
  - Hold buffer empty; state=S_IDLE; imem_req=0.
- States:
  - S_IDLE: imem_req=0; next cycle go to S_REQ. Used only after reset.
  - S_REQ: imem_req=1, imem_addr=pc.
  - S_HOLD: imem_req=0; buffer holds {buf_pc, buf_instr}.
- S_REQ, imem_gnt=1, pc_en=1, ifid_en=1:
  - IF/ID <= {pc, pc+4, imem_rdata, valid=1}; pc <= pc+4; stay in S_REQ.
  - Fetch-to-IF/ID latency is 1 cycle after the grant.
- S_REQ, imem_gnt=1, pc_en=0 or ifid_en=0:
  - buffer <= {pc, imem_rdata}; pc is unchanged; go to S_HOLD.
  - IF/ID holds if ifid_en=0; loads a bubble (valid=0) if ifid_en=1.
- S_REQ, imem_gnt=0:
  - pc unchanged; request stays asserted with a stable address.
  - IF/ID loads a bubble if ifid_en=1, otherwise holds.
- S_HOLD, pc_en=1 and ifid_en=1:
  - IF/ID <= {buf_pc, buf_pc+4, buf_instr, valid=1}; pc <= buf_pc+4; go to S_REQ.
- S_HOLD, otherwise: everything holds.
- redirect=1 overrides all of the above, in any state except reset:
  - pc <= {redirect_pc[31:2], 2'b00}; buffer dropped; ifid_valid <= 0 (even if ifid_en=0); go to S_REQ.
  - A grant in the same cycle is consumed and its data discarded.
- Priority: reset > redirect > stall > normal advance.
- imem_req/imem_addr are combinational from state and pc only; no dependence on imem_gnt.
- At most one outstanding request; a new address is presented only after a grant or a redirect.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- ifid_pc4 wraps identically.
- stall_cnt increments when ifid_valid=1 and ifid_en=0 and redirect=0; it saturates at all-ones and is never cleared except by reset.
- Reset asserted mid-stall or mid-request: all state cleared next edge; any grant in that cycle is ignored.

Test Plan:
- Reset, then imem_gnt tied to 1, enables=1, instr = addr^32'hA5A5_A5A5:
  - imem_req=0 for 1 cycle, then addresses 0, 4, 8.
  - ifid_pc follows 1 cycle behind each grant with matching ifid_instr; ifid_valid=1 from the 3rd cycle.
- Stall with grant pending: at pc=8, drive imem_gnt=1 and pc_en=ifid_en=0 for 3 cycles:
  - Instruction buffered; imem_req=0; IF/ID holds pc=4; stall_cnt=3.
  - On release: ifid_pc=8, then the next request is addr 12.
- Memory wait states: imem_gnt=0 for 4 cycles at pc=16:
  - imem_addr stable at 16; ifid_valid=0 after the first bubble.
  - Grant on cycle 5 gives ifid_pc=16.
- Redirect with simultaneous grant and stall: redirect=1, redirect_pc=32'h0000_1003, imem_gnt=1, ifid_en=0:
  - Next cycle ifid_valid=0, pc=32'h1000, imem_addr=32'h1000.
  - Granted data is never seen in IF/ID.
- Wrap-around: RESET_PC=32'hFFFF_FFFC, gnt=1:
  - ifid_pc=FFFF_FFFC with ifid_pc4=0; next fetch addr=0.
- Saturation and reset: CNT_W=2, hold the stall for 6 cycles → stall_cnt=3.
  - Assert rst=0 mid-stall → next edge stall_cnt=0, ifid_valid=0, state S_IDLE.

Source files
------------

// File: rtl/if_id_fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register.
// Ports: clk, rst (sync, active-low); pc_en, ifid_en (hazard enables);
//   redirect, redirect_pc (EX branch/jump); imem_req, imem_addr,
//   imem_gnt, imem_rdata (single-outstanding fetch port);
//   ifid_valid, ifid_pc, ifid_pc4, ifid_instr (to decode);
//   pc (fetch PC); stall_cnt (saturating IF/ID stall counter).
module if_id_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_en,
  input  logic             ifid_en,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_gnt,
  input  logic [31:0]      imem_rdata,
  output logic             ifid_valid,
  output logic [31:0]      ifid_pc,
  output logic [31:0]      ifid_pc4,
  output logic [31:0]      ifid_instr,
  output logic [31:0]      pc,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } ifid_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } hold_t;

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [31:0]      pc_q;
  logic [31:0]      pc_nx;
  ifid_t            ifid_q;
  ifid_t            ifid_nx;
  hold_t            hold_q;
  hold_t            hold_nx;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nx;

  logic             advance;
  logic [31:0]      target;
  logic [31:0]      fetch_pc4;
  logic [31:0]      hold_pc4;
  logic             cnt_full;

  assign advance   = pc_en & ifid_en;
  assign target    = redirect_pc & 32'hFFFF_FFFC;
  assign fetch_pc4 = pc_q + 32'd4;
  assign hold_pc4  = hold_q.pc + 32'd4;
  assign cnt_full  = &cnt_q;

  // Request side depends only on state and pc, never on the grant.
  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc_q & 32'hFFFF_FFFC;

  assign ifid_valid = ifid_q.valid;
  assign ifid_pc    = ifid_q.pc;
  assign ifid_pc4   = ifid_q.pc4;
  assign ifid_instr = ifid_q.instr;
  assign pc         = pc_q;
  assign stall_cnt  = cnt_q;

  always_comb begin
    state_nx = state;
    pc_nx    = pc_q;
    ifid_nx  = ifid_q;
    hold_nx  = hold_q;

    if (redirect) begin
      // A grant landing here is consumed; its data is dropped.
      pc_nx         = target;
      ifid_nx.valid = 1'b0;
      state_nx      = S_REQ;
    end else begin
      unique case (state)
        S_IDLE: begin
          state_nx = S_REQ;
        end
        S_REQ: begin
          unique case (1'b1)
            imem_gnt & advance: begin
              ifid_nx.valid = 1'b1;
              ifid_nx.pc    = pc_q;
              ifid_nx.pc4   = fetch_pc4;
              ifid_nx.instr = imem_rdata;
              pc_nx         = fetch_pc4;
            end
            imem_gnt & ~advance: begin
              // Park the returned word until the pipe frees up.
              hold_nx.pc    = pc_q;
              hold_nx.instr = imem_rdata;
              state_nx      = S_HOLD;
              if (ifid_en) ifid_nx.valid = 1'b0;
            end
            ~imem_gnt: begin
              if (ifid_en) ifid_nx.valid = 1'b0;
            end
            default: ;
          endcase
        end
        S_HOLD: begin
          if (advance) begin
            ifid_nx.valid = 1'b1;
            ifid_nx.pc    = hold_q.pc;
            ifid_nx.pc4   = hold_pc4;
            ifid_nx.instr = hold_q.instr;
            pc_nx         = hold_pc4;
            state_nx      = S_REQ;
          end
        end
        default: begin
          state_nx = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    cnt_nx = cnt_q;
    if (ifid_q.valid && !ifid_en && !redirect && !cnt_full)
      cnt_nx = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      pc_q   <= RESET_PC;
      ifid_q <= '0;
      hold_q <= '0;
      cnt_q  <= '0;
    end else begin
      state  <= state_nx;
      pc_q   <= pc_nx;
      ifid_q <= ifid_nx;
      hold_q <= hold_nx;
      cnt_q  <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Testbench for if_id_fetch_stage: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_if_id_fetch_stage;

  localparam logic [31:0] K = 32'hA5A5_A5A5;

  logic        clk;
  logic        rst;
  logic        pc_en;
  logic        ifid_en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_gnt;

  logic        a_req, w_req, s_req;
  logic [31:0] a_addr, w_addr, s_addr;
  logic [31:0] a_rdata, w_rdata, s_rdata;
  logic        a_v, w_v, s_v;
  logic [31:0] a_ipc, w_ipc, s_ipc;
  logic [31:0] a_pc4, w_pc4, s_pc4;
  logic [31:0] a_ins, w_ins, s_ins;
  logic [31:0] a_pc, w_pc, s_pc;
  logic [15:0] a_cnt, w_cnt;
  logic [1:0]  s_cnt;

  int n_chk = 0;
  int n_fail = 0;

  assign a_rdata = a_addr ^ K;
  assign w_rdata = w_addr ^ K;
  assign s_rdata = s_addr ^ K;

  if_id_fetch_stage dut (
    .clk(clk), .rst(rst), .pc_en(pc_en), .ifid_en(ifid_en),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(a_req), .imem_addr(a_addr), .imem_gnt(imem_gnt),
    .imem_rdata(a_rdata), .ifid_valid(a_v), .ifid_pc(a_ipc),
    .ifid_pc4(a_pc4), .ifid_instr(a_ins), .pc(a_pc),
    .stall_cnt(a_cnt)
  );

  if_id_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst), .pc_en(pc_en), .ifid_en(ifid_en),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(imem_gnt),
    .imem_rdata(w_rdata), .ifid_valid(w_v), .ifid_pc(w_ipc),
    .ifid_pc4(w_pc4), .ifid_instr(w_ins), .pc(w_pc),
    .stall_cnt(w_cnt)
  );

  if_id_fetch_stage #(.CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .pc_en(pc_en), .ifid_en(ifid_en),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(s_req), .imem_addr(s_addr), .imem_gnt(imem_gnt),
    .imem_rdata(s_rdata), .ifid_valid(s_v), .ifid_pc(s_ipc),
    .ifid_pc4(s_pc4), .ifid_instr(s_ins), .pc(s_pc),
    .stall_cnt(s_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    pc_en = 1'b1;
    ifid_en = 1'b1;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    imem_gnt = 1'b0;
    step();
  endtask

  task automatic test_reset();
    apply_reset();
    n_chk++;
    if (a_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_req got %b want 0", a_req);
    end
    n_chk++;
    if (a_v !== 1'b0 || a_pc !== 32'h0 || a_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state got v=%b pc=%h cnt=%h want 0/0/0",
               a_v, a_pc, a_cnt);
    end
    n_chk++;
    if (a_ipc !== 32'h0 || a_pc4 !== 32'h0 || a_ins !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_ifid got %h %h %h want zeros",
               a_ipc, a_pc4, a_ins);
    end
  endtask

  // Reset state already applied; stream from address 0.
  task automatic test_stream();
    rst = 1'b1;
    imem_gnt = 1'b1;
    n_chk++;
    if (a_req !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_req got %b want 0", a_req);
    end
    step();
    n_chk++;
    if (a_req !== 1'b1 || a_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL first_req got %b/%h want 1/0", a_req, a_addr);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      n_chk++;
      if (a_v !== 1'b1 || a_ipc !== 32'(i * 4) ||
          a_ins !== (32'(i * 4) ^ K) ||
          a_pc4 !== 32'(i * 4 + 4)) begin
        n_fail++;
        $display("FAIL stream%0d got v=%b pc=%h ins=%h want 1/%h",
                 i, a_v, a_ipc, a_ins, 32'(i * 4));
      end
      n_chk++;
      if (a_addr !== 32'(i * 4 + 4)) begin
        n_fail++;
        $display("FAIL stream_addr%0d got %h want %h",
                 i, a_addr, 32'(i * 4 + 4));
      end
    end
  endtask

  task automatic test_stall_hold();
    pc_en = 1'b0;
    ifid_en = 1'b0;
    imem_gnt = 1'b1;
    for (int i = 0; i < 3; i++) step();
    n_chk++;
    if (a_req !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_req got %b want 0", a_req);
    end
    n_chk++;
    if (a_v !== 1'b1 || a_ipc !== 32'h4) begin
      n_fail++;
      $display("FAIL hold_ifid got v=%b pc=%h want 1/4", a_v, a_ipc);
    end
    n_chk++;
    if (a_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL hold_cnt got %0d want 3", a_cnt);
    end
    pc_en = 1'b1;
    ifid_en = 1'b1;
    step();
    n_chk++;
    if (a_v !== 1'b1 || a_ipc !== 32'h8 || a_ins !== (32'h8 ^ K)) begin
      n_fail++;
      $display("FAIL release got pc=%h ins=%h want 8", a_ipc, a_ins);
    end
    n_chk++;
    if (a_req !== 1'b1 || a_addr !== 32'hC) begin
      n_fail++;
      $display("FAIL release_addr got %b/%h want 1/c", a_req, a_addr);
    end
  endtask

  task automatic test_wait_states();
    step();
    imem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_chk++;
      if (a_addr !== 32'h10 || a_req !== 1'b1 || a_v !== 1'b0) begin
        n_fail++;
        $display("FAIL wait%0d got addr=%h req=%b v=%b want 10/1/0",
                 i, a_addr, a_req, a_v);
      end
    end
    imem_gnt = 1'b1;
    step();
    n_chk++;
    if (a_v !== 1'b1 || a_ipc !== 32'h10) begin
      n_fail++;
      $display("FAIL wait_grant got v=%b pc=%h want 1/10", a_v, a_ipc);
    end
  endtask

  task automatic test_redirect();
    logic [15:0] cnt0;
    cnt0 = a_cnt;
    redirect = 1'b1;
    redirect_pc = 32'h0000_1003;
    imem_gnt = 1'b1;
    ifid_en = 1'b0;
    step();
    n_chk++;
    if (a_v !== 1'b0 || a_pc !== 32'h1000 || a_addr !== 32'h1000) begin
      n_fail++;
      $display("FAIL redirect got v=%b pc=%h addr=%h want 0/1000/1000",
               a_v, a_pc, a_addr);
    end
    n_chk++;
    if (a_cnt !== cnt0) begin
      n_fail++;
      $display("FAIL redirect_cnt got %0d want %0d", a_cnt, cnt0);
    end
    redirect = 1'b0;
    ifid_en = 1'b1;
    step();
    n_chk++;
    if (a_v !== 1'b1 || a_ipc !== 32'h1000 ||
        a_ins !== (32'h1000 ^ K)) begin
      n_fail++;
      $display("FAIL redirect_next got pc=%h ins=%h want 1000/%h",
               a_ipc, a_ins, 32'h1000 ^ K);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    rst = 1'b1;
    imem_gnt = 1'b1;
    step();
    n_chk++;
    if (w_addr !== 32'hFFFF_FFFC || w_req !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_req got %b/%h want 1/fffffffc", w_req, w_addr);
    end
    step();
    n_chk++;
    if (w_ipc !== 32'hFFFF_FFFC || w_pc4 !== 32'h0 || w_v !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_ifid got pc=%h pc4=%h want fffffffc/0",
               w_ipc, w_pc4);
    end
    n_chk++;
    if (w_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_addr got %h want 0", w_addr);
    end
  endtask

  task automatic test_saturate_reset();
    apply_reset();
    rst = 1'b1;
    imem_gnt = 1'b1;
    step();
    step();
    pc_en = 1'b0;
    ifid_en = 1'b0;
    for (int i = 0; i < 6; i++) step();
    n_chk++;
    if (s_cnt !== 2'd3 || s_v !== 1'b1) begin
      n_fail++;
      $display("FAIL saturate got cnt=%0d v=%b want 3/1", s_cnt, s_v);
    end
    n_chk++;
    if (a_cnt !== 16'd6) begin
      n_fail++;
      $display("FAIL wide_cnt got %0d want 6", a_cnt);
    end
    rst = 1'b0;
    step();
    n_chk++;
    if (s_cnt !== 2'd0 || s_v !== 1'b0 || s_req !== 1'b0 ||
        s_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset got cnt=%0d v=%b req=%b pc=%h want 0",
               s_cnt, s_v, s_req, s_pc);
    end
    rst = 1'b1;
    pc_en = 1'b1;
    ifid_en = 1'b1;
    step();
    n_chk++;
    if (s_req !== 1'b1 || s_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL after_reset got %b/%h want 1/0", s_req, s_addr);
    end
  endtask

  // Transaction-level model: fetcher is either requesting, parking one
  // returned word, or idle right after reset.
  task automatic test_random();
    bit          m_run;
    bit          m_park;
    logic [31:0] m_pc;
    logic [31:0] m_ppc;
    logic [31:0] m_pins;
    bit          m_v;
    logic [31:0] m_ipc;
    logic [31:0] m_ins;
    int          m_cnt;
    bit          go;
    apply_reset();
    rst = 1'b1;
    m_run = 0;
    m_park = 0;
    m_pc = 32'h0;
    m_ppc = 32'h0;
    m_pins = 32'h0;
    m_v = 0;
    m_ipc = 32'h0;
    m_ins = 32'h0;
    m_cnt = 0;
    for (int c = 0; c < 600; c++) begin
      imem_gnt = ($urandom_range(0, 9) < 7);
      pc_en = ($urandom_range(0, 9) < 8);
      ifid_en = ($urandom_range(0, 9) < 8);
      redirect = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
      #1;
      n_chk++;
      if (a_req !== (m_run && !m_park) ||
          (m_run && !m_park && a_addr !== m_pc)) begin
        n_fail++;
        $display("FAIL rnd_req c=%0d got %b/%h want %b/%h",
                 c, a_req, a_addr, m_run && !m_park, m_pc);
      end
      go = pc_en && ifid_en;
      if (m_v && !ifid_en && !redirect && m_cnt < 65535) m_cnt++;
      if (redirect) begin
        m_pc = {redirect_pc[31:2], 2'b00};
        m_park = 0;
        m_v = 0;
        m_run = 1;
      end else if (!m_run) begin
        m_run = 1;
      end else if (m_park) begin
        if (go) begin
          m_v = 1;
          m_ipc = m_ppc;
          m_ins = m_pins;
          m_pc = m_ppc + 32'd4;
          m_park = 0;
        end
      end else if (imem_gnt) begin
        if (go) begin
          m_v = 1;
          m_ipc = m_pc;
          m_ins = m_pc ^ K;
          m_pc = m_pc + 32'd4;
        end else begin
          m_park = 1;
          m_ppc = m_pc;
          m_pins = m_pc ^ K;
          if (ifid_en) m_v = 0;
        end
      end else if (ifid_en) begin
        m_v = 0;
      end
      step();
      n_chk++;
      if (a_v !== m_v || a_pc !== m_pc || a_cnt !== 16'(m_cnt)) begin
        n_fail++;
        $display("FAIL rnd_state c=%0d got v=%b pc=%h cnt=%0d want %b/%h/%0d",
                 c, a_v, a_pc, a_cnt, m_v, m_pc, m_cnt);
      end
      if (m_v) begin
        n_chk++;
        if (a_ipc !== m_ipc || a_ins !== m_ins ||
            a_pc4 !== m_ipc + 32'd4) begin
          n_fail++;
          $display("FAIL rnd_ifid c=%0d got %h/%h/%h want %h/%h",
                   c, a_ipc, a_ins, a_pc4, m_ipc, m_ins);
        end
      end
    end
    redirect = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_hold();
    test_wait_states();
    test_redirect();
    test_wrap();
    test_saturate_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
